// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 constants, working-variable struct, FSM state enum and round helper functions.
// No ports; imported by sha1_round and sha1_stream_core.
package sha1_pkg;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hefcdab89;
    localparam logic [31:0] H2 = 32'h98badcfe;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hc3d2e1f0;

    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;

    // Packed with a in the top bits so a whole hash state reads out as {H0..H4}.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_vars_t;

    localparam sha1_vars_t IV = '{a: H0, b: H1, c: H2, d: H3, e: H4};

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] f_parity(input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] k_sel(input logic [6:0] t);
        return t < 7'd20 ? K0 : t < 7'd40 ? K1 : t < 7'd60 ? K2 : K3;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round.
// Ports: v (a..e in), w (schedule word W[t]), t (round index 0..79), v_next (a..e out).
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_vars_t  v,
    input  logic [31:0] w,
    input  logic [6:0]  t,
    output sha1_vars_t  v_next
);

    logic [31:0] f;

    always_comb begin
        f = t < 7'd20                  ? f_ch(v.b, v.c, v.d)
          : (t >= 7'd40 && t < 7'd60) ? f_maj(v.b, v.c, v.d)
          :                             f_parity(v.b, v.c, v.d);
    end

    assign v_next = '{
        a: rotl(v.a, 5) + f + v.e + k_sel(t) + w,
        b: v.a,
        c: rotl(v.b, 30),
        d: v.c,
        e: v.d
    };

endmodule

// File: rtl/sha1_stream_core.sv
// sha1_stream_core: SHA-1 compression engine taking pre-padded 512-bit blocks as 32-bit words,
// running ROUNDS_PER_CYCLE rounds per clock and presenting the chained 160-bit digest.
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready word stream with in_first
// (word 0: start from IV) and in_last (word 15: final block); digest/digest_valid/digest_ready
// output handshake; busy high whenever the core is not idle.
module sha1_stream_core
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    output logic [159:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] STEP = 7'(R);
    localparam logic [6:0] LAST_STEP = 7'(80 - R);

    generate
        if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
            $error("sha1_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t      state, state_next;
    logic [3:0]  word_cnt;
    logic [6:0]  round_cnt;
    logic        first_l, last_l;
    logic        hs;
    logic [31:0] w [16];
    logic [31:0] ext [16+R];
    sha1_vars_t  v, h, base, h_sum;
    sha1_vars_t  chain [R+1];

    assign in_ready     = state == IDLE;
    assign digest_valid = state == OUT;
    assign busy         = state != IDLE;
    assign hs           = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hs && word_cnt == 4'd15) state_next = ROUND;
            ROUND:   if (round_cnt == LAST_STEP) state_next = UPDATE;
            UPDATE:  state_next = last_l ? OUT : IDLE;
            OUT:     if (digest_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The register holds W[t..t+15] at w[0..15]; ext appends the next R expanded words
    // so that this cycle's rounds read ext[0..R-1] and the window slides by R.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++) ext[16+j] = rotl(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j], 1);
    end

    assign chain[0] = v;

    for (genvar i = 0; i < R; i++) begin : g_round
        sha1_round u_round (
            .v      (chain[i]),
            .w      (ext[i]),
            .t      (round_cnt + 7'(i)),
            .v_next (chain[i+1])
        );
    end

    // A block started with in_first finalises against the IV, not the previous hash.
    assign base  = first_l ? IV : h;
    assign h_sum = '{a: base.a + v.a, b: base.b + v.b, c: base.c + v.c, d: base.d + v.d, e: base.e + v.e};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h         <= IV;
            digest    <= '0;
            word_cnt  <= '0;
            round_cnt <= '0;
            first_l   <= 1'b0;
            last_l    <= 1'b0;
        end else begin
            if (hs) begin
                word_cnt <= word_cnt + 4'd1;
                if (word_cnt == 4'd0) first_l <= in_first;
                if (word_cnt == 4'd15) last_l <= in_last;
            end
            if (state == ROUND) round_cnt <= round_cnt + STEP;
            if (state == UPDATE) begin
                h         <= h_sum;
                round_cnt <= '0;
                if (last_l) digest <= h_sum;
            end
        end
    end

    // Schedule and working variables need no reset: word 0 of every block reloads them.
    always_ff @(posedge clk) begin
        if (rst_n && hs) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= in_data;
            if (word_cnt == 4'd0) v <= in_first ? IV : h;
        end else if (state == ROUND) begin
            for (int i = 0; i < 16; i++) w[i] <= ext[i+R];
            v <= chain[R];
        end
    end

endmodule
